// File: rtl/spi_master_if.sv
// spi_master_if: controller handshake and SPI pin bundle for spi_master.
// The master modport is the spi_master view; the slave modport is the view of
// whatever sits across from it (local controller plus SPI peripheral/loopback).
interface spi_master_if #(
   parameter int SPI_DATA_SIZE = 8
);
   logic                     i_spi_start;
   logic [SPI_DATA_SIZE-1:0] i_spi_data_tx;
   logic [SPI_DATA_SIZE-1:0] o_spi_data_rx;
   logic                     o_spi_done;
   logic                     o_spi_busy;
   logic                     o_SCLK;
   logic                     o_SSEL;
   logic                     o_MOSI;
   logic                     i_MISO;

   modport master (
      input  i_spi_start, i_spi_data_tx, i_MISO,
      output o_spi_data_rx, o_spi_done, o_spi_busy, o_SCLK, o_SSEL, o_MOSI
   );

   modport slave (
      output i_spi_start, i_spi_data_tx, i_MISO,
      input  o_spi_data_rx, o_spi_done, o_spi_busy, o_SCLK, o_SSEL, o_MOSI
   );
endinterface

// File: rtl/spi_master.sv
// spi_master: byte-wide SPI master, mode 0 (CPOL=0, CPHA=0), MSB first.
// SCLK half-period is CLK_DIV i_clk cycles. A transfer is framed as
// LEAD (SSEL setup), alternating HIGH/LOW bit phases, TRAIL (SSEL hold) and
// GAP (SSEL high recovery) before the controller may start again.
// Optional build macro SPI_MASTER_BURST_EN: a start request on the last
// TRAIL cycle chains the next byte straight into LEAD with SSEL kept low.
module spi_master #(
   parameter int SPI_DATA_SIZE = 8,
   parameter int CLK_DIV       = 4
) (
   input  logic          i_clk,
   input  logic          i_rst,
   spi_master_if.master  bus
);

   localparam int BIT_W = (SPI_DATA_SIZE > 1) ? $clog2(SPI_DATA_SIZE) : 1;
   localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
   localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(SPI_DATA_SIZE - 1);
   localparam logic [DIV_W-1:0] LAST_CNT = DIV_W'(CLK_DIV - 1);

   typedef enum logic [2:0] {
      IDLE,
      LEAD,
      HIGH,
      LOW,
      TRAIL,
      GAP
   } state_t;

   state_t                   state;
   logic [DIV_W-1:0]         half_cnt;
   logic [BIT_W-1:0]         bit_cnt;
   logic [SPI_DATA_SIZE-1:0] tx_shift;
   logic [SPI_DATA_SIZE-1:0] rx_shift;
   logic [SPI_DATA_SIZE-1:0] rx_data;
   logic                     miso_meta;
   logic                     miso_sync;
   logic                     phase_end;
   logic                     sclk;
   logic                     ssel;
   logic                     mosi;
   logic                     busy;
   logic                     done;

   assign phase_end = (half_cnt == LAST_CNT);

   assign bus.o_SCLK        = sclk;
   assign bus.o_SSEL        = ssel;
   assign bus.o_MOSI        = mosi;
   assign bus.o_spi_busy    = busy;
   assign bus.o_spi_done    = done;
   assign bus.o_spi_data_rx = rx_data;

   // Two-flop synchronizer: MISO comes from an unrelated clock domain.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         miso_meta <= 1'b0;
         miso_sync <= 1'b0;
      end else begin
         miso_meta <= bus.i_MISO;
         miso_sync <= miso_meta;
      end
   end

   // Half-period timer: held at zero in IDLE, wraps to zero at every phase end.
   always_ff @(posedge i_clk) begin
      if (i_rst || state == IDLE || phase_end) begin
         half_cnt <= '0;
      end else begin
         half_cnt <= half_cnt + DIV_W'(1);
      end
   end

   // Transfer sequencer with registered SPI pins and handshake outputs.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state    <= IDLE;
         bit_cnt  <= '0;
         tx_shift <= '0;
         rx_shift <= '0;
         rx_data  <= '0;
         sclk     <= 1'b0;
         ssel     <= 1'b1;
         mosi     <= 1'b0;
         busy     <= 1'b0;
         done     <= 1'b0;
      end else begin
         done <= 1'b0;
         case (state)
            IDLE: begin
               busy <= 1'b0;
               if (bus.i_spi_start) begin
                  tx_shift <= bus.i_spi_data_tx;
                  mosi     <= bus.i_spi_data_tx[SPI_DATA_SIZE-1];
                  ssel     <= 1'b0;
                  busy     <= 1'b1;
                  bit_cnt  <= '0;
                  state    <= LEAD;
               end
            end
            LEAD: begin
               if (phase_end) begin
                  sclk  <= 1'b1;
                  state <= HIGH;
               end
            end
            HIGH: begin
               // Sample on the last high cycle, then drive the falling edge;
               // MOSI only ever moves together with that fall.
               if (phase_end) begin
                  rx_shift <= {rx_shift[SPI_DATA_SIZE-2:0], miso_sync};
                  sclk     <= 1'b0;
                  if (bit_cnt == LAST_BIT) begin
                     state <= TRAIL;
                  end else begin
                     tx_shift <= tx_shift << 1;
                     mosi     <= tx_shift[SPI_DATA_SIZE-2];
                     bit_cnt  <= bit_cnt + BIT_W'(1);
                     state    <= LOW;
                  end
               end
            end
            LOW: begin
               if (phase_end) begin
                  sclk  <= 1'b1;
                  state <= HIGH;
               end
            end
            TRAIL: begin
               if (phase_end) begin
                  rx_data <= rx_shift;
                  done    <= 1'b1;
`ifdef SPI_MASTER_BURST_EN
                  if (bus.i_spi_start) begin
                     // Chain the next byte: SSEL stays low, busy stays high.
                     tx_shift <= bus.i_spi_data_tx;
                     mosi     <= bus.i_spi_data_tx[SPI_DATA_SIZE-1];
                     bit_cnt  <= '0;
                     state    <= LEAD;
                  end else begin
                     ssel  <= 1'b1;
                     mosi  <= 1'b0;
                     state <= GAP;
                  end
`else
                  ssel  <= 1'b1;
                  mosi  <= 1'b0;
                  state <= GAP;
`endif
               end
            end
            GAP: begin
               // Start requests are deliberately not looked at here, so the
               // slave always sees SSEL high for at least CLK_DIV+1 cycles.
               if (phase_end) begin
                  busy  <= 1'b0;
                  state <= IDLE;
               end
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_spi_master.sv
// tb_spi_master: randomized and directed bench for spi_master (mode 0, 8 bits,
// CLK_DIV=4). MISO is either looped back from MOSI or driven by a small slave
// that shifts a byte out MSB first, changing after each SCLK fall.
`timescale 1ns/1ps
module tb_spi_master;

   localparam int N        = 8;
   localparam int DIV      = 4;
   localparam int XFER_CYC = (2 * N + 1) * DIV;

   logic clk = 1'b0;
   logic rst = 1'b1;

   spi_master_if #(.SPI_DATA_SIZE(N)) bus ();

   spi_master #(.SPI_DATA_SIZE(N), .CLK_DIV(DIV)) dut (
      .i_clk (clk),
      .i_rst (rst),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   int vectors     = 0;
   int miscompares = 0;
   int cyc         = 0;

   // Free-running cycle count used to timestamp observed events.
   always @(posedge clk) cyc <= cyc + 1;

   // Peripheral model: loopback, or shift slv_byte out after every SCLK fall.
   logic         loop_mode  = 1'b1;
   logic [N-1:0] slv_byte   = '0;
   int           slv_falls  = 0;
   logic         slv_sclk_q = 1'b0;

   always @(posedge clk) begin
      slv_sclk_q <= bus.o_SCLK;
      if (bus.o_SSEL !== 1'b0) slv_falls <= 0;
      else if (slv_sclk_q === 1'b1 && bus.o_SCLK === 1'b0) slv_falls <= slv_falls + 1;
   end

   assign bus.i_MISO = loop_mode ? bus.o_MOSI :
                       ((slv_falls < N) ? slv_byte[N-1-slv_falls] : 1'b0);

   // Pin monitor: counts edges, captures MOSI at SCLK rises, timestamps events.
   int           rises         = 0;
   int           viol          = 0;
   int           done_cnt      = 0;
   int           ssel_falls    = 0;
   int           ssel_fall_cyc = 0;
   int           ssel_rise_cyc = 0;
   int           done_cyc      = 0;
   int           done_prev_cyc = 0;
   int           busy_fall_cyc = 0;
   logic [N-1:0] mosi_sh       = '0;
   logic         sclk_m        = 1'b0;
   logic         ssel_m        = 1'b1;
   logic         busy_m        = 1'b0;
   logic         mosi_m        = 1'b0;

   always @(negedge clk) begin
      sclk_m <= bus.o_SCLK;
      ssel_m <= bus.o_SSEL;
      busy_m <= bus.o_spi_busy;
      mosi_m <= bus.o_MOSI;
      if (bus.o_SCLK === 1'b1 && sclk_m === 1'b0) begin
         rises   <= rises + 1;
         mosi_sh <= {mosi_sh[N-2:0], bus.o_MOSI};
      end
      if (bus.o_SCLK === 1'b1 && bus.o_MOSI !== mosi_m) viol <= viol + 1;
      if (bus.o_SSEL === 1'b0 && ssel_m === 1'b1) begin
         ssel_falls    <= ssel_falls + 1;
         ssel_fall_cyc <= cyc;
      end
      if (bus.o_SSEL === 1'b1 && ssel_m === 1'b0) ssel_rise_cyc <= cyc;
      if (bus.o_spi_done === 1'b1) begin
         done_cnt      <= done_cnt + 1;
         done_prev_cyc <= done_cyc;
         done_cyc      <= cyc;
      end
      if (bus.o_spi_busy === 1'b0 && busy_m === 1'b1) busy_fall_cyc <= cyc;
   end

   // Reference model: what the received byte must be for a given transfer.
   function automatic logic [N-1:0] model_rx(input logic [N-1:0] tx, input logic lb,
                                             input logic [N-1:0] slv);
      return lb ? tx : slv;
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      if (obs !== exp) begin
         miscompares++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, obs, exp, $time);
      end
   endtask

   task automatic start_pulse(input logic [N-1:0] tx);
      @(posedge clk); #1;
      bus.i_spi_start   = 1'b1;
      bus.i_spi_data_tx = tx;
      @(posedge clk); #1;
      bus.i_spi_start   = 1'b0;
   endtask

   task automatic wait_done(input string tag);
      int n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (bus.o_spi_done !== 1'b1 && n < 3 * XFER_CYC);
      chk(tag, bus.o_spi_done, 1);
   endtask

   task automatic wait_idle(input string tag);
      int n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (bus.o_spi_busy !== 1'b0 && n < 3 * XFER_CYC);
      chk(tag, bus.o_spi_busy, 0);
   endtask

   // One full transfer; inj_bit >= 0 pulses a stray start during that bit.
   task automatic xfer(input string tag, input logic [N-1:0] tx, input logic [N-1:0] exp_rx,
                       input int inj_bit);
      int r0 = rises;
      int d0 = done_cnt;
      int v0 = viol;
      int f0 = ssel_falls;
      int n  = 0;
      start_pulse(tx);
      if (inj_bit >= 0) begin
         while (rises - r0 < inj_bit + 1 && n < 2 * XFER_CYC) begin
            @(negedge clk);
            n++;
         end
         bus.i_spi_start   = 1'b1;
         bus.i_spi_data_tx = ~tx;
         @(posedge clk); #1;
         bus.i_spi_start   = 1'b0;
      end
      wait_done({tag, "_done"});
      wait_idle({tag, "_idle"});
      #1;
      chk({tag, "_rises"}, rises - r0, N);
      chk({tag, "_mosi"}, mosi_sh, tx);
      chk({tag, "_mosi_at_rise"}, viol - v0, 0);
      chk({tag, "_done_pulses"}, done_cnt - d0, 1);
      chk({tag, "_done_lat"}, done_cyc - ssel_fall_cyc, XFER_CYC);
      chk({tag, "_ssel_rise"}, ssel_rise_cyc - ssel_fall_cyc, XFER_CYC);
      chk({tag, "_busy_fall"}, busy_fall_cyc - done_cyc, DIV);
      chk({tag, "_rx"}, bus.o_spi_data_rx, exp_rx);
      chk({tag, "_frames"}, ssel_falls - f0, 1);
   endtask

   initial begin
      #400000;
      $display("FAIL watchdog: simulation did not finish, got timeout, expected $finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int           r0, d0, f0, g0, n;
      logic [N-1:0] t, s;
      logic         lb;

      bus.i_spi_start   = 1'b0;
      bus.i_spi_data_tx = '0;

      // Reset values
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_sclk", bus.o_SCLK, 0);
      chk("rst_ssel", bus.o_SSEL, 1);
      chk("rst_mosi", bus.o_MOSI, 0);
      chk("rst_busy", bus.o_spi_busy, 0);
      chk("rst_done", bus.o_spi_done, 0);
      chk("rst_rx", bus.o_spi_data_rx, 0);
      @(posedge clk); #1;
      rst = 1'b0;
      repeat (4) @(posedge clk);

      // Loopback 0x81
      loop_mode = 1'b1;
      xfer("lb81", 8'h81, model_rx(8'h81, 1'b1, 8'h00), -1);

      // Slave returns 0x3C while master sends 0xA5
      loop_mode = 1'b0;
      slv_byte  = 8'h3C;
      xfer("slv3c", 8'hA5, model_rx(8'hA5, 1'b0, 8'h3C), -1);

      // Randomized transfers
      for (int i = 0; i < 8; i++) begin
         t         = N'($urandom);
         s         = N'($urandom);
         lb        = 1'($urandom_range(0, 1));
         loop_mode = lb;
         slv_byte  = s;
         xfer("rand", t, model_rx(t, lb, s), -1);
      end

      // Stray start at bit 3 of a 0x00 transfer is ignored
      loop_mode = 1'b1;
      f0 = ssel_falls;
      xfer("busy_ign", 8'h00, model_rx(8'h00, 1'b1, 8'h00), 3);
      repeat (2 * XFER_CYC) @(negedge clk);
      chk("busy_ign_no_restart", ssel_falls - f0, 1);

      // Reset at 5th SCLK high abandons the byte; rx keeps 0x00 from above
      r0 = rises;
      d0 = done_cnt;
      n  = 0;
      start_pulse(8'hC3);
      while (rises - r0 < 5 && n < 2 * XFER_CYC) begin
         @(negedge clk);
         n++;
      end
      chk("rst_mid_reached", rises - r0, 5);
      rst = 1'b1;
      @(posedge clk); #1;
      chk("rst_mid_ssel", bus.o_SSEL, 1);
      chk("rst_mid_sclk", bus.o_SCLK, 0);
      chk("rst_mid_busy", bus.o_spi_busy, 0);
      chk("rst_mid_rx", bus.o_spi_data_rx, 0);
      rst = 1'b0;
      repeat (2 * XFER_CYC) @(negedge clk);
      chk("rst_mid_no_done", done_cnt - d0, 0);
      xfer("after_rst", 8'h5A, model_rx(8'h5A, 1'b1, 8'h00), -1);

      // Back-to-back: second start on the first IDLE cycle
      d0 = done_cnt;
      start_pulse(8'h3C);
      wait_done("b2b_done1");
      wait_idle("b2b_idle1");
      bus.i_spi_start   = 1'b1;
      bus.i_spi_data_tx = 8'hE7;
      @(posedge clk); #1;
      bus.i_spi_start   = 1'b0;
      g0 = ssel_rise_cyc;
      wait_done("b2b_done2");
      wait_idle("b2b_idle2");
      #1;
      chk("b2b_ssel_gap", ssel_fall_cyc - g0, DIV + 1);
      chk("b2b_dones", done_cnt - d0, 2);
      chk("b2b_rx", bus.o_spi_data_rx, model_rx(8'hE7, 1'b1, 8'h00));
      chk("b2b_mosi", mosi_sh, 8'hE7);

      // Start on the last GAP cycle is ignored
      f0 = ssel_falls;
      start_pulse(8'h69);
      wait_done("gap_done");
      repeat (DIV - 1) @(posedge clk);
      #1;
      bus.i_spi_start   = 1'b1;
      bus.i_spi_data_tx = 8'h96;
      @(posedge clk); #1;
      bus.i_spi_start   = 1'b0;
      repeat (2 * XFER_CYC) @(negedge clk);
      chk("gap_start_ignored", ssel_falls - f0, 1);
      chk("gap_busy", bus.o_spi_busy, 0);
      chk("gap_rx", bus.o_spi_data_rx, model_rx(8'h69, 1'b1, 8'h00));

`ifdef SPI_MASTER_BURST_EN
      // Burst: start held across TRAIL end chains 0x12 into 0x34
      r0 = rises;
      d0 = done_cnt;
      f0 = ssel_falls;
      n  = 0;
      start_pulse(8'h12);
      while (rises - r0 < N && n < 2 * XFER_CYC) begin
         @(negedge clk);
         n++;
      end
      bus.i_spi_start   = 1'b1;
      bus.i_spi_data_tx = 8'h34;
      wait_done("burst_done1");
      bus.i_spi_start   = 1'b0;
      chk("burst_rx1", bus.o_spi_data_rx, model_rx(8'h12, 1'b1, 8'h00));
      chk("burst_ssel_low", bus.o_SSEL, 0);
      wait_done("burst_done2");
      chk("burst_rx2", bus.o_spi_data_rx, model_rx(8'h34, 1'b1, 8'h00));
      wait_idle("burst_idle");
      #1;
      chk("burst_spacing", done_cyc - done_prev_cyc, XFER_CYC);
      chk("burst_frames", ssel_falls - f0, 1);
      chk("burst_dones", done_cnt - d0, 2);
      chk("burst_rises", rises - r0, 2 * N);
`endif

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
